// File: rtl/fpadd_pipe.sv
// Pipelined IEEE-754 adder/subtractor: align, add, normalise/round, one op per cycle.
// Three valid-tagged register stages with a folded backpressure chain.
module fpadd_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_s,
    output logic [2:0]   o_flags
);

    localparam int E   = MAN_W + 4;
    localparam int SW  = $clog2(E);
    localparam int LZW = $clog2(E + 1);
    localparam int XW  = EXP_W + 2;
    localparam int RW  = MAN_W + 2;
    localparam int unsigned SH_MAX = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [XW-1:0]    EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    // ---------------------------------------------------------------
    // Stage 1: unpack, classify, swap, align
    // ---------------------------------------------------------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea_raw, w_eb_raw, w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [MAN_W:0]   w_siga, w_sigb;
    logic             w_a_den, w_b_den, w_a_max, w_b_max;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic             w_a_big;
    logic [EXP_W-1:0] w_exp_big, w_exp_sml, w_diff;
    logic [E-1:0]     w_sig_big, w_sig_sml, w_mask, w_sig_aln;
    logic [SW-1:0]    w_sh;
    logic             w_invalid, w_inf, w_inf_sign, w_zero_neg, w_sign;

    assign w_sa     = i_a[W-1];
    assign w_sb     = i_b[W-1] ^ i_sub;
    assign w_ea_raw = i_a[W-2:MAN_W];
    assign w_eb_raw = i_b[W-2:MAN_W];
    assign w_fa     = i_a[MAN_W-1:0];
    assign w_fb     = i_b[MAN_W-1:0];

    // Subnormals are treated as exponent 1 with a zero hidden bit.
    assign w_a_den  = (w_ea_raw == '0);
    assign w_b_den  = (w_eb_raw == '0);
    assign w_ea     = w_a_den ? EXP_ONE : w_ea_raw;
    assign w_eb     = w_b_den ? EXP_ONE : w_eb_raw;
    assign w_siga   = {~w_a_den, w_fa};
    assign w_sigb   = {~w_b_den, w_fb};

    assign w_a_max  = &w_ea_raw;
    assign w_b_max  = &w_eb_raw;
    assign w_a_nan  = w_a_max & (|w_fa);
    assign w_b_nan  = w_b_max & (|w_fb);
    assign w_a_inf  = w_a_max & ~(|w_fa);
    assign w_b_inf  = w_b_max & ~(|w_fb);
    assign w_a_zero = w_a_den & ~(|w_fa);
    assign w_b_zero = w_b_den & ~(|w_fb);

    assign w_a_big   = {w_ea, w_siga} >= {w_eb, w_sigb};
    assign w_exp_big = w_a_big ? w_ea : w_eb;
    assign w_exp_sml = w_a_big ? w_eb : w_ea;
    assign w_sig_big = {(w_a_big ? w_siga : w_sigb), 3'b000};
    assign w_sig_sml = {(w_a_big ? w_sigb : w_siga), 3'b000};
    assign w_sign    = w_a_big ? w_sa : w_sb;

    assign w_diff    = w_exp_big - w_exp_sml;
    assign w_sh      = (32'(w_diff) > SH_MAX) ? SW'(SH_MAX) : SW'(w_diff);
    // Every bit pushed below the sticky position is folded into bit 0.
    assign w_mask    = ~({E{1'b1}} << w_sh);
    assign w_sig_aln = (w_sig_sml >> w_sh) | {{(E-1){1'b0}}, |(w_sig_sml & w_mask)};

    assign w_invalid  = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    assign w_inf      = (w_a_inf | w_b_inf) & ~w_invalid;
    assign w_inf_sign = w_a_inf ? w_sa : w_sb;
    assign w_zero_neg = w_a_zero & w_b_zero & w_sa & w_sb;

    logic             r1_valid, r1_sign, r1_eff_sub;
    logic [EXP_W-1:0] r1_exp;
    logic [E-1:0]     r1_big, r1_small;
    logic             r1_invalid, r1_inf, r1_inf_sign, r1_zero_neg;

    // ---------------------------------------------------------------
    // Stage 2: significand add/subtract
    // ---------------------------------------------------------------
    logic [E:0]       w_sum;

    assign w_sum = r1_eff_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                              : ({1'b0, r1_big} + {1'b0, r1_small});

    logic             r2_valid, r2_sign;
    logic [EXP_W-1:0] r2_exp;
    logic [E:0]       r2_sum;
    logic             r2_invalid, r2_inf, r2_inf_sign, r2_zero_neg;

    // ---------------------------------------------------------------
    // Stage 3: normalise, round, special-case selection
    // ---------------------------------------------------------------
    logic [E-1:0]     w_sum_lo, w_m;
    logic [LZW-1:0]   w_lzc, w_lsh;
    logic [EXP_W-1:0] w_exp_lim;
    logic [XW-1:0]    w_exp_n, w_exp_f;
    logic             w_up, w_ovf, w_inexact;
    logic [RW-1:0]    w_rnd;
    logic [MAN_W-1:0] w_frac_f;
    logic [W-1:0]     w_s_nxt;
    logic [2:0]       w_flags_nxt;

    assign w_sum_lo = r2_sum[E-1:0];

    always_comb begin
        w_lzc = LZW'(E);
        for (int i = 0; i < E; i++) begin
            if (w_sum_lo[i]) w_lzc = LZW'(E - 1 - i);
        end
    end

    // Left shift may not take the exponent below 1; what remains is subnormal.
    assign w_exp_lim = r2_exp - EXP_ONE;
    assign w_lsh     = (32'(w_lzc) <= 32'(w_exp_lim)) ? w_lzc : LZW'(w_exp_lim);

    assign w_m     = r2_sum[E] ? {r2_sum[E:2], r2_sum[1] | r2_sum[0]} : (w_sum_lo << w_lsh);
    assign w_exp_n = r2_sum[E] ? (XW'(r2_exp) + XW'(1)) : (XW'(r2_exp) - XW'(w_lsh));

    assign w_up      = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    assign w_rnd     = {1'b0, w_m[E-1:3]} + RW'(w_up);
    assign w_inexact = |w_m[2:0];

    always_comb begin
        w_exp_f  = '0;
        w_frac_f = w_rnd[MAN_W-1:0];
        if (w_rnd[MAN_W+1]) begin
            w_exp_f  = w_exp_n + XW'(1);
            w_frac_f = '0;
        end else if (w_rnd[MAN_W]) begin
            w_exp_f  = w_exp_n;
        end
    end

    assign w_ovf = (w_exp_f >= EXP_MAX);

    always_comb begin
        w_s_nxt     = {r2_sign, w_exp_f[EXP_W-1:0], w_frac_f};
        w_flags_nxt = {2'b00, w_inexact};
        if (r2_invalid) begin
            w_s_nxt     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags_nxt = 3'b100;
        end else if (r2_inf) begin
            w_s_nxt     = {r2_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags_nxt = 3'b000;
        end else if (r2_sum == '0) begin
            w_s_nxt     = {r2_zero_neg, {(W-1){1'b0}}};
            w_flags_nxt = 3'b000;
        end else if (w_ovf) begin
            w_s_nxt     = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags_nxt = 3'b011;
        end
    end

    // ---------------------------------------------------------------
    // Pipeline control and registers
    // ---------------------------------------------------------------
    logic r3_valid;
    logic w_adv1, w_adv2, w_adv3;

    assign w_adv3      = ~r3_valid | i_out_ready;
    assign w_adv2      = ~r2_valid | w_adv3;
    assign w_adv1      = ~r1_valid | w_adv2;
    assign o_in_ready  = ~i_rst & w_adv1;
    assign o_out_valid = r3_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_eff_sub  <= 1'b0;
            r1_exp      <= '0;
            r1_big      <= '0;
            r1_small    <= '0;
            r1_invalid  <= 1'b0;
            r1_inf      <= 1'b0;
            r1_inf_sign <= 1'b0;
            r1_zero_neg <= 1'b0;
        end else if (w_adv1) begin
            r1_valid <= i_in_valid;
            if (i_in_valid) begin
                r1_sign     <= w_sign;
                r1_eff_sub  <= w_sa ^ w_sb;
                r1_exp      <= w_exp_big;
                r1_big      <= w_sig_big;
                r1_small    <= w_sig_aln;
                r1_invalid  <= w_invalid;
                r1_inf      <= w_inf;
                r1_inf_sign <= w_inf_sign;
                r1_zero_neg <= w_zero_neg;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_exp      <= '0;
            r2_sum      <= '0;
            r2_invalid  <= 1'b0;
            r2_inf      <= 1'b0;
            r2_inf_sign <= 1'b0;
            r2_zero_neg <= 1'b0;
        end else if (w_adv2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign     <= r1_sign;
                r2_exp      <= r1_exp;
                r2_sum      <= w_sum;
                r2_invalid  <= r1_invalid;
                r2_inf      <= r1_inf;
                r2_inf_sign <= r1_inf_sign;
                r2_zero_neg <= r1_zero_neg;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r3_valid <= 1'b0;
            o_s      <= '0;
            o_flags  <= '0;
        end else if (w_adv3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                o_s     <= w_s_nxt;
                o_flags <= w_flags_nxt;
            end
        end
    end

endmodule
